// File: rtl/neureka_tcdm_responder_pkg.sv
// Shared TCDM definitions for the NEUREKA memory-side responder.
package neureka_package;

  localparam logic [31:0] NEUREKA_TCDM_ERR_DATA = 32'hBADA_CCE5;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_req_t;

  typedef struct packed {
    logic        r_valid;
    logic [31:0] r_data;
  } tcdm_rsp_t;

endpackage

// File: rtl/neureka_tcdm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves to winner+1 after any busy cycle.
module neureka_tcdm_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned LN = $clog2(N);

  logic [LN-1:0] ptr_q, ptr_d, idx, win;

  always_comb begin
    gnt = '0;
    win = ptr_q;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + LN'(k);
      if (req[idx] && (gnt == '0)) begin
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
    ptr_d = (|req) ? win + LN'(1) : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/neureka_tcdm_responder.sv
// MP-port TCDM endpoint: word-interleaved flop banks, per-bank round-robin, 1-cycle read latency.
module neureka_tcdm_responder
  import neureka_package::*;
#(
  parameter int unsigned MP        = 4,
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [MP-1:0]        tcdm_req,
  output logic [MP-1:0]        tcdm_gnt,
  input  logic [MP-1:0][31:0]  tcdm_add,
  input  logic [MP-1:0]        tcdm_wen,
  input  logic [MP-1:0][3:0]   tcdm_be,
  input  logic [MP-1:0][31:0]  tcdm_data,
  output logic [MP-1:0][31:0]  tcdm_r_data,
  output logic [MP-1:0]        tcdm_r_valid,
  output logic                 err_o,
  output logic [31:0]          conflict_cnt_o
);

  localparam int unsigned LMP  = $clog2(MP);
  localparam int unsigned LD   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(MP * DEPTH * 4);

  tcdm_req_t             prt [MP];
  logic [31:0]           off [MP];
  logic [MP-1:0]         in_range;
  logic [MP-1:0][LMP-1:0] bank_sel;
  logic [MP-1:0][LD-1:0]  row_sel;

  logic [MP-1:0][MP-1:0]  bank_req, bank_gnt;
  logic [MP-1:0][LMP-1:0] win;
  logic [MP-1:0]          busy;

  logic [31:0] mem [MP][DEPTH];
  tcdm_rsp_t   rsp_d [MP];
  tcdm_rsp_t   rsp_q [MP];

  logic [LMP:0] n_denied;
  logic [32:0]  cnt_sum;

  // Unsigned offset wraps for addresses below BASE_ADDR, so one compare covers both bounds.
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      prt[p] = '{req: tcdm_req[p], add: tcdm_add[p], wen: tcdm_wen[p],
                 be: tcdm_be[p], data: tcdm_data[p]};
      off[p]      = prt[p].add - BASE_ADDR;
      in_range[p] = off[p] < SPAN;
      bank_sel[p] = off[p][2 +: LMP];
      row_sel[p]  = off[p][2 + LMP +: LD];
    end
  end

  for (genvar b = 0; b < MP; b++) begin : g_bank
    always_comb begin
      for (int p = 0; p < MP; p++)
        bank_req[b][p] = prt[p].req & in_range[p] & (bank_sel[p] == LMP'(b));
    end

    neureka_tcdm_rr_arbiter #(.N(MP)) i_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req    (bank_req[b]),
      .gnt    (bank_gnt[b])
    );
  end

  always_comb begin
    logic hit;
    for (int b = 0; b < MP; b++) begin
      busy[b] = |bank_gnt[b];
      win[b]  = '0;
      for (int p = 0; p < MP; p++)
        if (bank_gnt[b][p]) win[b] = LMP'(p);
    end
    n_denied = '0;
    for (int p = 0; p < MP; p++) begin
      hit = 1'b0;
      for (int b = 0; b < MP; b++) hit = hit | bank_gnt[b][p];
      tcdm_gnt[p] = prt[p].req & (~in_range[p] | hit);
      n_denied    = n_denied + (LMP+1)'(prt[p].req & in_range[p] & ~tcdm_gnt[p]);
    end
    cnt_sum = {1'b0, conflict_cnt_o} + 33'(n_denied);
  end

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      rsp_d[p].r_valid = tcdm_gnt[p];
      if (!tcdm_gnt[p] || (in_range[p] && !prt[p].wen)) rsp_d[p].r_data = '0;
      else if (!in_range[p])                             rsp_d[p].r_data = NEUREKA_TCDM_ERR_DATA;
      else                                               rsp_d[p].r_data = mem[bank_sel[p]][row_sel[p]];
      tcdm_r_valid[p] = rsp_q[p].r_valid;
      tcdm_r_data[p]  = rsp_q[p].r_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < MP; b++)
        for (int r = 0; r < DEPTH; r++) mem[b][r] <= '0;
    end else begin
      for (int b = 0; b < MP; b++)
        if (busy[b] && !prt[win[b]].wen)
          for (int i = 0; i < 4; i++)
            if (prt[win[b]].be[i])
              mem[b][row_sel[win[b]]][8*i +: 8] <= prt[win[b]].data[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < MP; p++) rsp_q[p] <= '0;
      err_o          <= 1'b0;
      conflict_cnt_o <= '0;
    end else begin
      for (int p = 0; p < MP; p++) rsp_q[p] <= rsp_d[p];
      if (clear_i) begin
        err_o          <= 1'b0;
        conflict_cnt_o <= '0;
      end else begin
        if (|(tcdm_req & ~in_range)) err_o <= 1'b1;
        conflict_cnt_o <= cnt_sum[32] ? '1 : cnt_sum[31:0];
      end
    end
  end

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// Directed and randomized checks of neureka_tcdm_responder against a flat-memory reference model.
module tb_neureka_tcdm_responder;

  localparam int          MP    = 4;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          SPAN  = MP * DEPTH * 4;
  localparam logic [31:0] ERRD  = 32'hBADA_CCE5;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [MP-1:0]       req, wen, gnt, rvalid;
  logic [MP-1:0][31:0] add, wdata, rdata;
  logic [MP-1:0][3:0]  be;
  logic                err;
  logic [31:0]         cnt;

  always #5 clk = ~clk;

  neureka_tcdm_responder #(.MP(MP), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .tcdm_req       (req),
    .tcdm_gnt       (gnt),
    .tcdm_add       (add),
    .tcdm_wen       (wen),
    .tcdm_be        (be),
    .tcdm_data      (wdata),
    .tcdm_r_data    (rdata),
    .tcdm_r_valid   (rvalid),
    .err_o          (err),
    .conflict_cnt_o (cnt)
  );

  int total = 0, bad = 0;

  logic [31:0]   m_mem [MP*DEPTH];
  int            m_ptr [MP];
  logic          m_err;
  longint        m_cnt;
  logic [MP-1:0] e_gnt;
  logic [31:0]   e_rd [MP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit inr(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + SPAN);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MP*DEPTH; i++) m_mem[i] = '0;
    for (int b = 0; b < MP; b++) m_ptr[b] = 0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic idle();
    req = '0; wen = '1; be = '0; wdata = '0; clear = 1'b0;
    for (int p = 0; p < MP; p++) add[p] = BASE;
  endtask

  // One bus cycle: inputs already driven at the falling edge.
  task automatic step();
    int win, q, n;
    bit any_oor;
    #1;
    e_gnt = '0;
    for (int p = 0; p < MP; p++)
      if (req[p] && !inr(add[p])) e_gnt[p] = 1'b1;
    for (int b = 0; b < MP; b++) begin
      win = -1;
      for (int k = 0; k < MP; k++) begin
        q = (m_ptr[b] + k) % MP;
        if (win < 0 && req[q] && inr(add[q]) && (word_of(add[q]) % MP) == b) win = q;
      end
      if (win >= 0) begin
        e_gnt[win] = 1'b1;
        m_ptr[b]   = (win + 1) % MP;
      end
    end
    for (int p = 0; p < MP; p++) begin
      if (!inr(add[p]))  e_rd[p] = ERRD;
      else if (wen[p])   e_rd[p] = m_mem[word_of(add[p])];
      else               e_rd[p] = '0;
    end
    chk("gnt", 32'(gnt), 32'(e_gnt));
    n = 0;
    any_oor = 1'b0;
    for (int p = 0; p < MP; p++) begin
      if (req[p] && !inr(add[p])) any_oor = 1'b1;
      if (req[p] && inr(add[p]) && !e_gnt[p]) n++;
      if (e_gnt[p] && inr(add[p]) && !wen[p])
        for (int i = 0; i < 4; i++)
          if (be[p][i]) m_mem[word_of(add[p])][8*i +: 8] = wdata[p][8*i +: 8];
    end
    if (clear) begin
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      if (any_oor) m_err = 1'b1;
      m_cnt = m_cnt + n;
      if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
    end
    @(posedge clk);
    #1;
    chk("r_valid", 32'(rvalid), 32'(e_gnt));
    for (int p = 0; p < MP; p++)
      if (e_gnt[p]) chk($sformatf("r_data[%0d]", p), rdata[p], e_rd[p]);
    chk("err", 32'(err), 32'(m_err));
    chk("conflict_cnt", cnt, 32'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_r_valid", 32'(rvalid), 32'h0);
    chk("rst_r_data", rdata[0] | rdata[1] | rdata[2] | rdata[3], 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_cnt", cnt, 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // aligned wide read
    for (int p = 0; p < MP; p++) begin req[p] = 1'b1; add[p] = BASE + 32'(4*p); end
    step();
    chk("wide_r_valid", 32'(rvalid), 32'hF);

    idle();
    req[2] = 1'b1; wen[2] = 1'b0; add[2] = BASE + 8; wdata[2] = 32'hCAFE_F00D; be[2] = 4'b0101;
    step();
    chk("wr_r_data", rdata[2], 32'h0);
    wen[2] = 1'b1;
    step();
    chk("raw_r_data", rdata[2], 32'h00FE_000D);

    // two readers on bank 1
    idle();
    req[0] = 1'b1; add[0] = BASE + 4;
    req[1] = 1'b1; add[1] = BASE + 20;
    step();
    chk("conf_c1", 32'(rvalid), 32'h1);
    req[0] = 1'b0;
    step();
    chk("conf_c2", 32'(rvalid), 32'h2);
    chk("conf_cnt", cnt, 32'h1);

    idle();
    req[3] = 1'b1; add[3] = BASE - 4;
    step();
    chk("oor_r_data", rdata[3], ERRD);
    idle();
    step();
    chk("oor_sticky", 32'(err), 32'h1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_err", 32'(err), 32'h0);
    chk("clear_cnt", cnt, 32'h0);

    // unaligned wide read
    for (int p = 0; p < MP; p++) begin req[p] = 1'b1; add[p] = BASE + 32'(4 + 4*p); end
    step();
    chk("uwide_r_valid", 32'(rvalid), 32'hF);
    chk("uwide_cnt", cnt, 32'h0);

    // reset during the grant cycle: no pulse
    idle();
    req[0] = 1'b1; add[0] = BASE + 8;
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 chk("rst_no_pulse", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(negedge clk);

    // reset right after a grant: pending valid dropped at once
    req[2] = 1'b1; wen[2] = 1'b0; add[2] = BASE + 8; wdata[2] = 32'h1234_5678; be[2] = 4'hF;
    step();
    rst_n = 1'b0;
    #1 chk("rst_async_valid", 32'(rvalid), 32'h0);
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req[1] = 1'b1; add[1] = BASE + 8;
    step();
    chk("rst_mem_zero", rdata[1], 32'h0);

    // randomized traffic; denied ports hold their request
    idle();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < MP; p++) begin
        if (!(req[p] && !e_gnt[p])) begin
          int kind;
          req[p]   = ($urandom_range(0, 9) < 7);
          wen[p]   = $urandom_range(0, 1) == 1;
          be[p]    = 4'($urandom_range(0, 15));
          wdata[p] = $urandom;
          kind     = $urandom_range(0, 15);
          if (kind == 0)      add[p] = BASE - 32'(4 * $urandom_range(1, 4));
          else if (kind == 1) add[p] = BASE + SPAN + 32'(4 * $urandom_range(0, 3));
          else if (kind < 5)  add[p] = BASE + 32'(4 * $urandom_range(0, MP*DEPTH-1));
          else                add[p] = BASE + 32'(4 * $urandom_range(0, 4*MP-1)) + 32'($urandom_range(0, 3));
        end
      end
      clear = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
